fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined rv32i cores. It decouples the instruction memory from the decode stage. It issues sequential word fetches and keeps up to DEPTH requests in flight, tolerating any response latency of one cycle or more. Returned instructions are buffered in an in-order queue with a valid/ready handshake, and a branch/jump redirect flushes the queue and discards responses to stale requests, so decode stalls no longer freeze the memory interface.

---
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - rv32i instruction-fetch front end with credit-limited requests and in-order queue
module fetch_unit #(
    parameter logic [31:0] RESET_PC_VALUE = 32'h0000_0000,
    parameter int          DEPTH          = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] op_inst_addr,
    output logic        op_inst_req,
    input  logic        ip_inst_valid,
    input  logic [31:0] ip_inst_from_imem,
    input  logic        ip_redirect,
    input  logic [31:0] ip_redirect_pc,
    output logic        op_fetch_valid,
    output logic [31:0] op_fetch_inst,
    output logic [31:0] op_fetch_pc,
    input  logic        ip_fetch_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic [CW:0]   credits_used;
    logic          req, drop, push, pop;
    logic [31:0]   target_pc;

    always_comb begin
        credits_used = {1'b0, inflight_q} + {1'b0, count_q};
        // Every queue slot is reserved at issue time, so a response can always be pushed.
        req       = !reset && !ip_redirect && (credits_used < (CW+1)'(DEPTH));
        drop      = ip_inst_valid && ((discard_q != '0) || ip_redirect);
        push      = ip_inst_valid && !drop;
        pop       = (count_q != '0) && ip_fetch_ready && !ip_redirect;
        target_pc = {ip_redirect_pc[31:2], 2'b00};

        fetch_pc_d = req  ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = push ? resp_pc_q + 32'd4  : resp_pc_q;
        inflight_d = inflight_q + CW'(req) - CW'(ip_inst_valid);
        discard_d  = discard_q - CW'(ip_inst_valid && (discard_q != '0));
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);

        if (ip_redirect) begin
            // Everything still in flight belongs to the old path.
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            discard_d  = inflight_q - CW'(ip_inst_valid);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC_VALUE;
            resp_pc_q  <= RESET_PC_VALUE;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[wr_ptr_q]   <= resp_pc_q;
            inst_mem[wr_ptr_q] <= ip_inst_from_imem;
        end
    end

    assign op_inst_addr   = fetch_pc_q;
    assign op_inst_req    = req;
    assign op_fetch_valid = (count_q != '0);
    assign op_fetch_inst  = inst_mem[rd_ptr_q];
    assign op_fetch_pc    = pc_mem[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized bench for fetch_unit against a queue-level reference model
module tb_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] op_inst_addr;
    logic        op_inst_req;
    logic        ip_inst_valid = 1'b0;
    logic [31:0] ip_inst_from_imem = '0;
    logic        ip_redirect = 1'b0;
    logic [31:0] ip_redirect_pc = '0;
    logic        op_fetch_valid;
    logic [31:0] op_fetch_inst;
    logic [31:0] op_fetch_pc;
    logic        ip_fetch_ready = 1'b0;

    fetch_unit #(.RESET_PC_VALUE(RPC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .op_inst_addr     (op_inst_addr),
        .op_inst_req      (op_inst_req),
        .ip_inst_valid    (ip_inst_valid),
        .ip_inst_from_imem(ip_inst_from_imem),
        .ip_redirect      (ip_redirect),
        .ip_redirect_pc   (ip_redirect_pc),
        .op_fetch_valid   (op_fetch_valid),
        .op_fetch_inst    (op_fetch_inst),
        .op_fetch_pc      (op_fetch_pc),
        .ip_fetch_ready   (ip_fetch_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit stale; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    req_t        outst[$];
    ent_t        q[$];
    logic [31:0] m_pc = RPC;
    bit          m_init = 0;
    bit          exp_req;
    int          cyc = 0;
    int          lat_lo = 1, lat_hi = 1;
    int          checks = 0, failures = 0;

    bit          reset_v = 1, ready_v = 0, redirect_v = 0;
    logic [31:0] target_v = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_check();
        reset             = reset_v;
        ip_redirect       = redirect_v && !reset_v;
        ip_redirect_pc    = target_v;
        ip_fetch_ready    = ready_v;
        ip_inst_valid     = !reset_v && (outst.size() > 0) && (outst[0].due <= cyc);
        ip_inst_from_imem = $urandom;
        #1;
        exp_req = !reset_v && !ip_redirect && (outst.size() + q.size() < DEPTH);
        chk("inst_req", op_inst_req, exp_req);
        if (m_init) begin
            chk("inst_addr", op_inst_addr, m_pc);
            chk("fetch_valid", op_fetch_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("fetch_pc", op_fetch_pc, q[0].pc);
                chk("fetch_inst", op_fetch_inst, q[0].inst);
            end
        end
    endtask

    task automatic advance();
        req_t r;
        if (reset_v) begin
            outst.delete();
            q.delete();
            m_pc   = RPC;
            m_init = 1;
        end else begin
            if (q.size() != 0 && ready_v && !ip_redirect) void'(q.pop_front());
            if (ip_inst_valid) begin
                r = outst.pop_front();
                if (!r.stale && !ip_redirect) begin
                    q.push_back('{r.pc, ip_inst_from_imem});
                    chk("queue_bound", q.size() <= DEPTH, 1);
                end
            end
            if (exp_req) begin
                outst.push_back('{m_pc, 1'b0, cyc + int'($urandom_range(lat_lo, lat_hi))});
                m_pc = m_pc + 32'd4;
            end
            if (ip_redirect) begin
                foreach (outst[i]) outst[i].stale = 1;
                q.delete();
                m_pc = {target_v[31:2], 2'b00};
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        drive_check();
        advance();
    endtask

    task automatic do_reset(input int n);
        reset_v = 1; redirect_v = 0;
        for (int i = 0; i < n; i++) step();
        reset_v = 0;
    endtask

    task automatic scan_first(input string name, input logic [31:0] exp_pc);
        bit found = 0;
        for (int i = 0; i < 20; i++) begin
            drive_check();
            if (op_fetch_valid && !found) begin
                chk(name, op_fetch_pc, exp_pc);
                found = 1;
            end
            advance();
        end
        if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        @(negedge clk);

        // Streaming with 1-cycle memory
        lat_lo = 1; lat_hi = 1; ready_v = 1;
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            drive_check();
            if (i < 3) chk("A_addr", op_inst_addr, RPC + 32'(4 * i));
            if (i >= 2) begin
                chk("A_valid", op_fetch_valid, 1);
                chk("A_fpc", op_fetch_pc, RPC + 32'(4 * (i - 2)));
            end
            advance();
        end

        // Back-pressure fills all credits
        ready_v = 0;
        do_reset(2);
        for (int i = 0; i < 7; i++) begin
            drive_check();
            if (i < 4) begin
                chk("B_req", op_inst_req, 1);
                chk("B_addr", op_inst_addr, RPC + 32'(4 * i));
            end else begin
                chk("B_stall", op_inst_req, 0);
            end
            advance();
        end
        ready_v = 1;
        drive_check();
        chk("B_req_at_pop", op_inst_req, 0);
        chk("B_head0", op_fetch_pc, RPC);
        advance();
        drive_check();
        chk("B_resume", op_inst_req, 1);
        chk("B_resume_addr", op_inst_addr, RPC + 32'h10);
        chk("B_head1", op_fetch_pc, RPC + 32'h4);
        advance();
        step();

        // Redirect near the top of the address space, low bits ignored
        redirect_v = 1; target_v = 32'hFFFF_FFFB;
        drive_check();
        chk("C_req_redir", op_inst_req, 0);
        advance();
        redirect_v = 0;
        for (int i = 0; i < 6; i++) begin
            drive_check();
            if (i < 3) chk("C_addr", op_inst_addr, 32'hFFFF_FFF8 + 32'(4 * i));
            if (i < 2) chk("C_flushed", op_fetch_valid, 0);
            else chk("C_fpc", op_fetch_pc, 32'hFFFF_FFF8 + 32'(4 * (i - 2)));
            advance();
        end

        // 3-cycle memory, two stale requests in flight
        lat_lo = 3; lat_hi = 3;
        do_reset(2);
        step(); step();
        redirect_v = 1; target_v = 32'h200;
        drive_check();
        chk("D_req_redir", op_inst_req, 0);
        advance();
        redirect_v = 0;
        scan_first("D_first_pc", 32'h200);

        // Redirect coincides with a response, inflight = 2
        lat_lo = 2; lat_hi = 2;
        do_reset(2);
        step(); step();
        redirect_v = 1; target_v = 32'h200;
        step();
        redirect_v = 0;
        scan_first("E_first_pc", 32'h200);

        // Reset mid-stream with 3 queued entries
        lat_lo = 1; lat_hi = 1; ready_v = 0;
        do_reset(2);
        for (int i = 0; i < 4; i++) step();
        reset_v = 1;
        drive_check();
        chk("F_pre_valid", op_fetch_valid, 1);
        advance();
        drive_check();
        chk("F_valid", op_fetch_valid, 0);
        chk("F_req", op_inst_req, 0);
        chk("F_addr", op_inst_addr, RPC);
        advance();
        reset_v = 0;
        drive_check();
        chk("F_restart", op_inst_req, 1);
        chk("F_restart_addr", op_inst_addr, RPC);
        advance();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                lat_lo = 1;
                lat_hi = int'($urandom_range(1, 6));
            end
            ready_v    = ($urandom_range(0, 3) != 0);
            redirect_v = ($urandom_range(0, 24) == 0);
            target_v   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            reset_v    = ($urandom_range(0, 599) == 0);
            step();
        end
        reset_v = 0; redirect_v = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
